// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand/result handshake bundle for alu_pipe.
// The master side is the operand producer / result consumer; the slave side is the ALU.
interface alu_pipe_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             negative;
    logic             overflow;
    logic             zero;
    logic [CNT_W-1:0] ovf_count;
    logic             ovf_clr;

    modport master (
        output in_valid, opcode, a, b, out_ready, ovf_clr,
        input  in_ready, out_valid, out, negative, overflow, zero, ovf_count
    );

    modport slave (
        input  in_valid, opcode, a, b, out_ready, ovf_clr,
        output in_ready, out_valid, out, negative, overflow, zero, ovf_count
    );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage registered ALU with valid/ready on both sides.
// Stage 1 holds {opcode,a,b}; stage 2 holds the result and flags.
// A saturating counter tracks overflowing results accepted by the consumer.
// Optional build macro ALU_SATURATE_EN clamps ADD/SUB results on signed overflow.
module alu_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_pipe_if.slave bus
);
    localparam int SH_W = $clog2(WIDTH);
    localparam int MSB  = WIDTH - 1;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLL = 3'b101,
        OP_SRL = 3'b110,
        OP_SRA = 3'b111
    } op_e;

    logic             s1_valid_q;
    op_e              s1_op_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;

    logic             s2_valid_q;
    logic [WIDTH-1:0] res_q;
    logic             neg_q;
    logic             ovf_q;
    logic             zero_q;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic             s1_ready;
    logic             s2_ready;
    logic             out_xfer;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [SH_W-1:0]  sh;
    logic [WIDTH-1:0] res_d;
    logic             ovf_d;

    assign s2_ready = !s2_valid_q || bus.out_ready;
    assign s1_ready = !s1_valid_q || s2_ready;
    assign out_xfer = s2_valid_q && bus.out_ready;

    // Stage 1: capture the operand beat whenever the stage can advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= OP_ADD;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
        end else if (s1_ready) begin
            s1_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                s1_op_q <= op_e'(bus.opcode);
                s1_a_q  <= bus.a;
                s1_b_q  <= bus.b;
            end
        end
    end

    // ALU datapath on the stage-1 operands
    always_comb begin
        sum   = s1_a_q + s1_b_q;
        diff  = s1_a_q - s1_b_q;
        sh    = s1_b_q[SH_W-1:0];
        res_d = '0;
        ovf_d = 1'b0;
        case (s1_op_q)
            OP_ADD: begin
                res_d = sum;
                ovf_d = (s1_a_q[MSB] == s1_b_q[MSB]) && (sum[MSB] != s1_a_q[MSB]);
            end
            OP_SUB: begin
                res_d = diff;
                ovf_d = (s1_a_q[MSB] != s1_b_q[MSB]) && (diff[MSB] != s1_a_q[MSB]);
            end
            OP_AND:  res_d = s1_a_q & s1_b_q;
            OP_OR:   res_d = s1_a_q | s1_b_q;
            OP_XOR:  res_d = s1_a_q ^ s1_b_q;
            OP_SLL:  res_d = s1_a_q << sh;
            OP_SRL:  res_d = s1_a_q >> sh;
            OP_SRA:  res_d = $signed(s1_a_q) >>> sh;
            default: res_d = '0;
        endcase
`ifdef ALU_SATURATE_EN
        // On overflow the true result's sign is operand A's sign, for both ADD and SUB
        if (ovf_d) begin
            res_d = s1_a_q[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    // Stage 2: register result and flags; holds while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            res_q      <= '0;
            neg_q      <= 1'b0;
            ovf_q      <= 1'b0;
            zero_q     <= 1'b0;
        end else if (s2_ready) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                res_q  <= res_d;
                neg_q  <= res_d[MSB];
                ovf_q  <= ovf_d;
                zero_q <= (res_d == '0);
            end
        end
    end

    // Overflow event counter next state: clear wins, increment saturates
    always_comb begin
        cnt_d = cnt_q;
        if (bus.ovf_clr) begin
            cnt_d = '0;
        end else if (out_xfer && ovf_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Overflow event counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.in_ready  = s1_ready;
    assign bus.out_valid = s2_valid_q;
    assign bus.out       = res_q;
    assign bus.negative  = neg_q;
    assign bus.overflow  = ovf_q;
    assign bus.zero      = zero_q;
    assign bus.ovf_count = cnt_q;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: self-checking bench for alu_pipe (WIDTH=8, CNT_W=2).
`timescale 1ns/1ps
module tb_alu_pipe;
    localparam int W = 8;
    localparam int C = 2;

    typedef struct packed {
        logic [7:0] out;
        logic       neg;
        logic       ovf;
        logic       zero;
    } res_t;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        res_t       exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(W), .CNT_W(C)) bus();
    alu_pipe #(.WIDTH(W), .CNT_W(C)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int   n_pass = 0;
    int   n_total = 0;
    res_t exp_q[$];
    res_t got_q[$];
    int   cnt_m = 0;
    bit   prev_hold = 0;
    res_t prev_res;
    vec_t vecs[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h @%0t", name, act, exp, $time);
    endtask

    // Reference: signed integer arithmetic, overflow = result outside [-128,127]
    function automatic res_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int sa, sb, ua, r, p, sh;
        res_t x;
        sa = $signed(a); sb = $signed(b); ua = a;
        sh = b % 8; p = 1 << sh;
        x.ovf = 1'b0;
        r = 0;
        case (op)
            3'd0, 3'd1: begin
                r = (op == 3'd0) ? sa + sb : sa - sb;
                x.ovf = (r > 127) || (r < -128);
`ifdef ALU_SATURATE_EN
                if (r > 127) r = 127;
                if (r < -128) r = -128;
`endif
            end
            3'd2: r = ua & int'(b);
            3'd3: r = ua | int'(b);
            3'd4: r = ua ^ int'(b);
            3'd5: r = ua * p;
            3'd6: r = ua / p;
            default: r = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);
        endcase
        x.out  = 8'(r);
        x.neg  = x.out[7];
        x.zero = (x.out == 8'h00);
        return x;
    endfunction

    function automatic res_t cur_res();
        return {bus.out, bus.negative, bus.overflow, bus.zero};
    endfunction

    // Observe accepted beats, delivered results, output stability and the counter
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_hold)
                check("hold_stable", {bus.out_valid, cur_res()}, {1'b1, prev_res});
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_res  = cur_res();
            check("ovf_count_model", 64'(bus.ovf_count), 64'(cnt_m));
            if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.opcode, bus.a, bus.b));
            if (bus.out_valid && bus.out_ready) got_q.push_back(cur_res());
            if (bus.ovf_clr) cnt_m = 0;
            else if (bus.out_valid && bus.out_ready && bus.overflow && cnt_m < 3) cnt_m++;
        end else begin
            prev_hold = 0;
            cnt_m = 0;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        bus.in_valid = 1'b1; bus.opcode = op; bus.a = a; bus.b = b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.ovf_clr = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        exp_q.delete(); got_q.delete();
    endtask

    task automatic wait_out(input string name);
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid) begin ok = 1; break; end
            tick();
        end
        if (!ok) check({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t e3[3];
        bus.in_valid = 0; bus.opcode = 0; bus.a = 0; bus.b = 0;
        bus.out_ready = 0; bus.ovf_clr = 0;

        vecs[0]  = '{3'd0, 8'h7F, 8'h01, res_t'{8'h80, 1'b1, 1'b1, 1'b0}};
        vecs[1]  = '{3'd1, 8'h05, 8'h05, res_t'{8'h00, 1'b0, 1'b0, 1'b1}};
        vecs[2]  = '{3'd7, 8'h80, 8'h03, res_t'{8'hF0, 1'b1, 1'b0, 1'b0}};
        vecs[3]  = '{3'd0, 8'h80, 8'h80, res_t'{8'h00, 1'b0, 1'b1, 1'b1}};
        vecs[4]  = '{3'd1, 8'h80, 8'h01, res_t'{8'h7F, 1'b0, 1'b1, 1'b0}};
        vecs[5]  = '{3'd1, 8'h7F, 8'hFF, res_t'{8'h80, 1'b1, 1'b1, 1'b0}};
        vecs[6]  = '{3'd2, 8'hF0, 8'h3C, res_t'{8'h30, 1'b0, 1'b0, 1'b0}};
        vecs[7]  = '{3'd3, 8'hF0, 8'h0F, res_t'{8'hFF, 1'b1, 1'b0, 1'b0}};
        vecs[8]  = '{3'd4, 8'hAA, 8'hAA, res_t'{8'h00, 1'b0, 1'b0, 1'b1}};
        vecs[9]  = '{3'd5, 8'h81, 8'h01, res_t'{8'h02, 1'b0, 1'b0, 1'b0}};
        vecs[10] = '{3'd6, 8'h80, 8'h0B, res_t'{8'h10, 1'b0, 1'b0, 1'b0}};
        vecs[11] = '{3'd7, 8'h7F, 8'h02, res_t'{8'h1F, 1'b0, 1'b0, 1'b0}};
        vecs[12] = '{3'd5, 8'h01, 8'h07, res_t'{8'h80, 1'b1, 1'b0, 1'b0}};
        vecs[13] = '{3'd0, 8'h40, 8'h3F, res_t'{8'h7F, 1'b0, 1'b0, 1'b0}};
        vecs[14] = '{3'd7, 8'h80, 8'h0F, res_t'{8'hFF, 1'b1, 1'b0, 1'b0}};
`ifdef ALU_SATURATE_EN
        vecs[0].exp = res_t'{8'h7F, 1'b0, 1'b1, 1'b0};
        vecs[3].exp = res_t'{8'h80, 1'b1, 1'b1, 1'b0};
        vecs[4].exp = res_t'{8'h80, 1'b1, 1'b1, 1'b0};
        vecs[5].exp = res_t'{8'h7F, 1'b0, 1'b1, 1'b0};
`endif

        // Reset state
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 0);
        check("rst_ovf_count", 64'(bus.ovf_count), 0);
        check("rst_out_flags", 64'(cur_res()), 0);
        do_reset();
        check("rst_in_ready", 64'(bus.in_ready), 1);

        // Table vectors, one beat at a time, with latency check
        bus.out_ready = 1'b1;
        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d_in_ready", i), 64'(bus.in_ready), 1);
            tick();
            bus.in_valid = 1'b0;
            check($sformatf("vec%0d_early", i), 64'(bus.out_valid), 0);
            tick();
            check($sformatf("vec%0d_valid", i), 64'(bus.out_valid), 1);
            check($sformatf("vec%0d_res", i), 64'(cur_res()), 64'(vecs[i].exp));
            tick();
        end

        // Back-pressure: three beats with the consumer stalled
        do_reset();
        bus.out_ready = 1'b0;
        drive(3'd0, 8'h7F, 8'h01); tick();
        drive(3'd1, 8'h10, 8'h20); tick();
        drive(3'd7, 8'hC0, 8'h01);
        check("bp_in_ready_low", 64'(bus.in_ready), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_still_blocked", 64'(bus.in_ready), 0);
            check("bp_head", 64'(cur_res()), 64'(model(3'd0, 8'h7F, 8'h01)));
        end
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (4) tick();
        e3[0] = model(3'd0, 8'h7F, 8'h01);
        e3[1] = model(3'd1, 8'h10, 8'h20);
        e3[2] = model(3'd7, 8'hC0, 8'h01);
        check("bp_count", 64'(got_q.size()), 3);
        for (int i = 0; i < 3 && i < got_q.size(); i++)
            check($sformatf("bp_order%0d", i), 64'(got_q[i]), 64'(e3[i]));

        // Saturating counter: five overflowing ADDs
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(3'd0, 8'h7F, 8'h01); tick();
        end
        bus.in_valid = 1'b0;
        repeat (4) tick();
        check("cnt_saturated", 64'(bus.ovf_count), 3);

        // Clear coincident with an overflow transfer
        bus.out_ready = 1'b0;
        drive(3'd0, 8'h7F, 8'h01); tick();
        bus.in_valid = 1'b0;
        wait_out("clr");
        bus.out_ready = 1'b1; bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        check("clr_priority", 64'(bus.ovf_count), 0);
        check("clr_drained", 64'(bus.out_valid), 0);
        tick();
        check("clr_stays", 64'(bus.ovf_count), 0);

        // Reset with two beats in flight
        drive(3'd0, 8'h7F, 8'h01); tick();
        bus.in_valid = 1'b0;
        repeat (3) tick();
        check("pre_rst_count", 64'(bus.ovf_count), 1);
        bus.out_ready = 1'b0;
        drive(3'd0, 8'h7F, 8'h02); tick();
        drive(3'd0, 8'h80, 8'hFF); tick();
        bus.in_valid = 1'b0;
        check("inflight_valid", 64'(bus.out_valid), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 0);
        check("midrst_count", 64'(bus.ovf_count), 0);
        tick(); tick();
        rst_n = 1'b1;
        got_q.delete(); exp_q.delete();
        bus.out_ready = 1'b1;
        repeat (5) tick();
        check("no_stale_results", 64'(got_q.size()), 0);
        check("no_stale_valid", 64'(bus.out_valid), 0);

        // Random stream against the reference model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bus.in_valid  = ($urandom_range(3, 0) != 0);
            bus.opcode    = 3'($urandom_range(7, 0));
            bus.a         = 8'($urandom);
            bus.b         = 8'($urandom);
            bus.out_ready = ($urandom_range(2, 0) != 0);
            bus.ovf_clr   = ($urandom_range(24, 0) == 0);
            tick();
        end
        bus.in_valid = 1'b0; bus.ovf_clr = 1'b0; bus.out_ready = 1'b1;
        for (int i = 0; i < 10 && got_q.size() != exp_q.size(); i++) tick();
        check("rand_count", 64'(got_q.size()), 64'(exp_q.size()));
        check("rand_nonempty", 64'(exp_q.size() > 100), 1);
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("rand%0d", i), 64'(got_q[i]), 64'(exp_q[i]));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
